// File: rtl/iseq_loader.sv
// iseq_loader: host-side writer for the instruction FIFO / dispatcher handshake.
// Optional build macro: ISEQ_LOADER_STATS_EN enables the completed-sequence counter.
module iseq_loader #(
  parameter logic [3:0] END_OPCODE = 4'b0000,
  parameter int         MAX_LEN    = 1024,
  parameter int         LEN_W      = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             host_valid,
  input  logic [31:0]      host_data,
  output logic             host_ready,
  output logic             instr_fifo_wr,
  output logic [31:0]      instr_fifo_data,
  input  logic             instr_fifo_full,
  output logic             process_iseq,
  input  logic             dispatcher_busy,
  output logic             loader_busy,
  output logic             seq_done,
  output logic [LEN_W-1:0] seq_len,
  output logic             err_overflow,
  output logic [15:0]      seq_count
);

  typedef enum logic [1:0] {
    LOAD,
    LAUNCH,
    WAIT_BUSY,
    DRAIN
  } state_e;

  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] seq_len_q;
  logic             ovf_q, ovf_d;
  logic             acc;
  logic             is_end;
  logic             wr;

  // host is held off in reset and outside LOAD
  assign host_ready = rst_n & (state_q == LOAD) & ~instr_fifo_full;
  assign acc        = host_valid & host_ready;
  assign is_end     = (host_data[31:28] == END_OPCODE);
  assign wr         = acc & ~is_end & (len_q < MAX_L);

  assign instr_fifo_wr   = wr;
  assign instr_fifo_data = wr ? host_data : '0;
  assign process_iseq    = (state_q == LAUNCH);
  assign loader_busy     = (state_q != LOAD);
  assign seq_done        = (state_q == DRAIN) & ~dispatcher_busy;
  assign seq_len         = seq_len_q;
  assign err_overflow    = ovf_q;

  // next state, length and overflow flag
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      LOAD: begin
        if (acc) begin
          if (!is_end) begin
            if (len_q < MAX_L) len_d = len_q + 1'b1;
            else               ovf_d = 1'b1;
          end else if (len_q != '0) begin
            state_d = LAUNCH;
          end
        end
      end
      LAUNCH:    state_d = WAIT_BUSY;
      WAIT_BUSY: if (dispatcher_busy) state_d = DRAIN;
      DRAIN: begin
        if (!dispatcher_busy) begin
          state_d = LOAD;
          len_d   = '0;
        end
      end
      default:   state_d = LOAD;
    endcase
  end

  // state, length, reported length and sticky overflow registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= LOAD;
      len_q     <= '0;
      seq_len_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
      if (wr) seq_len_q <= len_d;
    end
  end

`ifdef ISEQ_LOADER_STATS_EN
  logic [15:0] cnt_q;

  // wrapping count of completed sequences
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        cnt_q <= '0;
    else if (seq_done) cnt_q <= cnt_q + 16'd1;
  end

  assign seq_count = cnt_q;
`else
  assign seq_count = '0;
`endif

endmodule

// File: doc/iseq_loader.md
# iseq_loader

Host-side writer for the instruction-sequence path. It accepts a 32-bit instruction stream from the host interface and writes each instruction into the instruction FIFO that the sequence dispatcher drains. On the end-of-sequence instruction it pulses `process_iseq` and holds off the host until the dispatcher has finished executing the sequence. It is the producer end of the FIFO/`process_iseq`/`dispatcher_busy` handshake consumed by the dispatcher.

## Interface
- `END_OPCODE`, 4'b0000: value of `host_data[31:28]` that marks end-of-sequence.
- `MAX_LEN`, 1024: maximum number of instructions per sequence; equals the instruction FIFO depth.
- `LEN_W`, 11: width of the length counter; must satisfy 2^LEN_W > MAX_LEN.

Ports:
- `clk` in 1: the single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `host_valid` in 1: host word valid.
- `host_data` in 32: host instruction word.
- `host_ready` out 1: loader accepts the word this cycle.
- `instr_fifo_wr` out 1: instruction FIFO write strobe.
- `instr_fifo_data` out 32: instruction FIFO write data.
- `instr_fifo_full` in 1: instruction FIFO full.
- `process_iseq` out 1: one-cycle start pulse to the dispatcher.
- `dispatcher_busy` in 1: dispatcher is executing.
- `loader_busy` out 1: high in any state other than LOAD.
- `seq_done` out 1: one-cycle pulse when a launched sequence completes.
- `seq_len` out LEN_W: instructions written into the FIFO for the current or last sequence.
- `err_overflow` out 1: sticky flag; set when more than MAX_LEN instructions arrive before END.
- `seq_count` out 16: number of completed sequences (see Configuration).

## Operation
- FSM states: LOAD, LAUNCH, WAIT_BUSY, DRAIN. Reset state is LOAD.
- `host_ready = (state==LOAD) & ~instr_fifo_full`. A word is accepted when `host_valid & host_ready`.
- LOAD, accepted word with opcode ≠ END_OPCODE:
  - If `len < MAX_LEN`: `instr_fifo_wr=1`, `instr_fifo_data=host_data` in the same cycle (combinational), and `len` increments.
  - Otherwise the word is discarded, `err_overflow` is set and `len` saturates at MAX_LEN.
- LOAD, accepted END word:
  - If `len==0`: the word is ignored and the state stays LOAD. No pulse is issued.
  - If `len>0`: next state is LAUNCH. The END word is never written to the FIFO.
- LAUNCH: `process_iseq=1` for exactly this cycle, then go to WAIT_BUSY.
- WAIT_BUSY: stay until `dispatcher_busy=1`, then go to DRAIN.
- DRAIN: stay until `dispatcher_busy=0`. On the exit cycle `seq_done=1`, state returns to LOAD and `len` clears on the next cycle.
- `seq_len` shows the live `len` while loading. It holds the final value from LAUNCH until the first write of the next sequence.
- `err_overflow` clears only on reset. A truncated sequence is still launched.
- `rst_n` low at any time, including mid-load or mid-DRAIN:
  - State goes to LOAD.
  - `len`, `seq_len`, `seq_count` and `err_overflow` clear to 0.
  - Any partial FIFO contents are the FIFO owner's responsibility.

## Timing
- Reset values: `host_ready`=0 while in reset (then follows `~instr_fifo_full`); `instr_fifo_wr`=0, `instr_fifo_data`=0, `process_iseq`=0, `loader_busy`=0, `seq_done`=0, `seq_len`=0, `err_overflow`=0, `seq_count`=0.
- Host-to-FIFO write latency: 0 cycles. Throughput: 1 word per cycle while not full.
- END accepted at cycle N: `process_iseq` is high at N+1. The dispatcher raises `dispatcher_busy` at N+2; WAIT_BUSY sees it and moves to DRAIN at N+3.
- `process_iseq`, `loader_busy` and `seq_done` are decoded from registered state. They are glitch-free and one cycle wide where stated.
- `instr_fifo_full` asserting in the same cycle as `host_valid` blocks acceptance. No word is lost.
- `dispatcher_busy` already high at LAUNCH: WAIT_BUSY exits on its first cycle.

## Configuration
- `ISEQ_LOADER_STATS_EN` defined: `seq_count` increments by one with wrap-around on every `seq_done`.
- `ISEQ_LOADER_STATS_EN` undefined: `seq_count` is tied to 0 and the counter logic is absent.

## Test plan
- Reset release, then 3 words 0x1000_0001..0x1000_0003 followed by 0x0000_0000 → 3 FIFO writes with matching data; `seq_len`=3; `process_iseq` pulses once, exactly 1 cycle after END is accepted.
- Model `dispatcher_busy` high 2 cycles after the pulse for 10 cycles → `host_ready`=0 throughout; `seq_done` on the falling edge; LOAD resumes; `seq_count`=1 with the macro, 0 without.
- END sent as the first word → no FIFO writes, no `process_iseq`, state remains LOAD.
- `instr_fifo_full` held high for 5 cycles with `host_valid` high → `host_ready`=0, no writes; after release the words are written in order with none dropped.
- MAX_LEN+2 words followed by END → MAX_LEN writes; `err_overflow`=1 and stays set; `process_iseq` still pulses.
- `rst_n` pulsed low during DRAIN → all outputs return to their reset values immediately; a subsequent 1-word sequence runs normally.
